// File: rtl/music_pkg.sv
// Shared definitions for the song sequencer: FSM state codes, tempo select codes, note codes.
package music_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_ROM = 3'd2;
  localparam logic [2:0] ST_PLAY     = 3'd3;
  localparam logic [2:0] ST_PAUSED   = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  localparam logic [1:0] TEMPO_X1     = 2'b00;
  localparam logic [1:0] TEMPO_X2     = 2'b01;
  localparam logic [1:0] TEMPO_HALF   = 2'b10;
  localparam logic [1:0] TEMPO_X1_ALT = 2'b11;

  localparam logic [5:0] REST = 6'd0;
  localparam int unsigned NOTES_PER_OCTAVE = 12;

  function automatic logic [5:0] note_code_of(input int unsigned octave, input int unsigned note);
    return 6'(octave * NOTES_PER_OCTAVE + note);
  endfunction

  function automatic int unsigned step_period(input logic [1:0] sel, input int unsigned base);
    case (sel)
      TEMPO_X2:   return base >> 1;
      TEMPO_HALF: return base << 1;
      default:    return base;
    endcase
  endfunction

endpackage

// File: rtl/step_timer.sv
// Per-step cycle counter with tempo-dependent period, end-of-step strobe and articulation-gap compare.
module step_timer #(
  parameter int unsigned TICKS_PER_STEP = 4194304,
  parameter int unsigned GAP_TICKS      = 262144
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       clr,
  input  logic       load,
  input  logic       inc,
  input  logic [1:0] tempo_sel,
  output logic       step_last,
  output logic       gap_ok_nx
);
  import music_pkg::*;

  localparam int CTR_W = $clog2(TICKS_PER_STEP) + 2;

  logic [CTR_W-1:0] ctr_q;
  logic [CTR_W-1:0] ctr_nx;
  logic [CTR_W-1:0] period_q;

  always_comb begin
    ctr_nx = ctr_q;
    if (clr || load)
      ctr_nx = '0;
    else if (inc)
      ctr_nx = ctr_q + CTR_W'(1);
  end

  // Period is latched only at step start so tempo changes land on the next step.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      ctr_q    <= '0;
      period_q <= CTR_W'(TICKS_PER_STEP);
    end else begin
      ctr_q <= ctr_nx;
      if (load)
        period_q <= CTR_W'(step_period(tempo_sel, TICKS_PER_STEP));
    end
  end

  assign step_last = (ctr_q == period_q - CTR_W'(1));
  assign gap_ok_nx = (ctr_nx >= CTR_W'(GAP_TICKS));

endmodule

// File: rtl/song_sequencer.sv
// Song ROM stepper with play/pause/stop transport and gated note_on.
// Optional macro SEQ_LOOP_EN: wrap to step 0 at song end instead of stopping in DONE.
module song_sequencer #(
  parameter int unsigned TICKS_PER_STEP = 4194304,
  parameter int unsigned GAP_TICKS      = 262144,
  parameter int unsigned SONG_LEN       = 243,
  parameter int unsigned ADDR_W         = 8
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic [1:0]        tempo_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [5:0]        note_code,
  output logic              note_on,
  output logic              playing,
  output logic              song_done
);
  import music_pkg::*;

  logic [2:0]        state_q, state_n, saved_q, saved_n;
  logic [ADDR_W-1:0] addr_n;
  logic [5:0]        code_n;
  logic              done_n, note_on_n;
  logic              clr, load, inc;
  logic              step_last, gap_ok_nx;
  logic              play_go;
  logic              unused_rom_bits;

  assign unused_rom_bits = &{1'b0, rom_data[7:6]};
  assign play_go = play & ~pause;

  step_timer #(
    .TICKS_PER_STEP(TICKS_PER_STEP),
    .GAP_TICKS     (GAP_TICKS)
  ) u_timer (
    .clk      (clk),
    .RESET    (RESET),
    .clr      (clr),
    .load     (load),
    .inc      (inc),
    .tempo_sel(tempo_sel),
    .step_last(step_last),
    .gap_ok_nx(gap_ok_nx)
  );

  // The unpaused transition is computed first; pause then parks it in saved_n so resume continues exactly there.
  always_comb begin
    state_n = state_q;
    saved_n = saved_q;
    addr_n  = rom_addr;
    code_n  = note_code;
    done_n  = 1'b0;
    clr     = 1'b0;
    load    = 1'b0;
    inc     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (play_go) begin
          state_n = ST_FETCH;
          addr_n  = '0;
          load    = 1'b1;
        end
      end
      ST_FETCH: begin
        inc     = 1'b1;
        state_n = ST_WAIT_ROM;
      end
      ST_WAIT_ROM: begin
        inc     = 1'b1;
        code_n  = rom_data[5:0];
        state_n = ST_PLAY;
      end
      ST_PLAY: begin
        if (!step_last) begin
          inc = 1'b1;
        end else if (rom_addr < ADDR_W'(SONG_LEN - 1)) begin
          addr_n  = rom_addr + ADDR_W'(1);
          state_n = ST_FETCH;
          load    = 1'b1;
        end else begin
          done_n = 1'b1;
`ifdef SEQ_LOOP_EN
          addr_n  = '0;
          state_n = ST_FETCH;
          load    = 1'b1;
`else
          code_n  = REST;
          state_n = ST_DONE;
          clr     = 1'b1;
`endif
        end
      end
      ST_PAUSED: begin
        if (play_go)
          state_n = saved_q;
      end
      default: state_n = ST_IDLE;
    endcase

    if (pause && (state_q == ST_FETCH || state_q == ST_WAIT_ROM || state_q == ST_PLAY)
        && state_n != ST_DONE) begin
      saved_n = state_n;
      state_n = ST_PAUSED;
    end

    if (stop) begin
      state_n = ST_IDLE;
      addr_n  = '0;
      code_n  = REST;
      done_n  = 1'b0;
      clr     = 1'b1;
      load    = 1'b0;
      inc     = 1'b0;
    end

    note_on_n = (state_n == ST_PLAY) && (code_n != REST) && gap_ok_nx;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      saved_q   <= ST_IDLE;
      rom_addr  <= '0;
      note_code <= REST;
      note_on   <= 1'b0;
      playing   <= 1'b0;
      song_done <= 1'b0;
    end else begin
      state_q   <= state_n;
      saved_q   <= saved_n;
      rom_addr  <= addr_n;
      note_code <= code_n;
      note_on   <= note_on_n;
      playing   <= (state_n == ST_FETCH) || (state_n == ST_WAIT_ROM) || (state_n == ST_PLAY);
      song_done <= done_n;
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: 4-step song, 16-cycle steps, 4-cycle gap, registered ROM model.
module tb_song_sequencer;

  logic       clk = 1'b0;
  logic       RESET;
  logic       play, pause, stop;
  logic [1:0] tempo_sel;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [5:0] note_code;
  logic       note_on, playing, song_done;

  logic [7:0] rom_mem [0:3];
  int n_checks = 0;
  int n_fail   = 0;
  int hi;

  always #5 clk = ~clk;

  song_sequencer #(
    .TICKS_PER_STEP(16),
    .GAP_TICKS     (4),
    .SONG_LEN      (4),
    .ADDR_W        (8)
  ) dut (
    .clk      (clk),
    .RESET    (RESET),
    .play     (play),
    .pause    (pause),
    .stop     (stop),
    .tempo_sel(tempo_sel),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .note_code(note_code),
    .note_on  (note_on),
    .playing  (playing),
    .song_done(song_done)
  );

  // Step 3 byte has bits [7:6] set; only bits [5:0] (29) may reach note_code.
  initial begin
    rom_mem[0] = 8'd25;
    rom_mem[1] = 8'd0;
    rom_mem[2] = 8'd30;
    rom_mem[3] = 8'hDD;
  end

  always @(posedge clk)
    rom_data <= (rom_addr < 8'd4) ? rom_mem[rom_addr[1:0]] : 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    RESET = 1'b1; play = 1'b0; pause = 1'b0; stop = 1'b0; tempo_sel = 2'b00;
    #3;
    check("rst_addr", rom_addr, 0);
    check("rst_code", note_code, 0);
    check("rst_note_on", note_on, 0);
    check("rst_playing", playing, 0);
    check("rst_done", song_done, 0);
    step(2);
    RESET = 1'b0;
    step(1);

    // Step 0 at tempo x1
    play = 1'b1; step(1); play = 1'b0;
    check("s0c0_addr", rom_addr, 0);
    check("s0c0_playing", playing, 1);
    check("s0c0_note_on", note_on, 0);
    step(1);
    check("s0c1_code", note_code, 0);
    step(1);
    check("s0c2_code", note_code, 25);
    check("s0c2_note_on", note_on, 0);
    step(1);
    check("s0c3_note_on", note_on, 0);
    step(1);
    check("s0c4_note_on", note_on, 1);
    step(11);
    check("s0c15_note_on", note_on, 1);
    check("s0c15_addr", rom_addr, 0);
    step(1);
    check("s1c0_addr", rom_addr, 1);
    check("s1c0_note_on", note_on, 0);

    // Step 1 is a rest
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      hi += int'(note_on);
      step(1);
    end
    check("rest_note_on_cycles", hi, 0);
    check("s2c0_addr", rom_addr, 2);

    // Pause 10 cycles in step 2
    step(8);
    pause = 1'b1; step(1); pause = 1'b0;
    check("pause_playing", playing, 0);
    check("pause_addr", rom_addr, 2);
    check("pause_code", note_code, 30);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      hi += int'(note_on);
      if (i != 9) step(1);
    end
    check("pause_note_on_cycles", hi, 0);
    play = 1'b1; step(1); play = 1'b0;
    check("resume_note_on", note_on, 1);
    check("resume_playing", playing, 1);
    step(6);
    check("s2_late_addr", rom_addr, 2);
    step(1);
    check("s3c0_addr", rom_addr, 3);
    step(2);
    check("s3_code_masked", note_code, 29);
    step(13);
    check("s3c15_addr", rom_addr, 3);
    check("s3c15_done", song_done, 0);
    step(1);
`ifdef SEQ_LOOP_EN
    check("end_done", song_done, 1);
    check("end_playing", playing, 1);
    check("end_addr", rom_addr, 0);
    step(2);
    check("loop_done_clear", song_done, 0);
    check("loop_code", note_code, 25);
`else
    check("end_done", song_done, 1);
    check("end_playing", playing, 0);
    check("end_note_on", note_on, 0);
    check("end_code", note_code, 0);
    check("end_addr", rom_addr, 3);
    step(1);
    check("done_pulse_clear", song_done, 0);
    check("done_hold_addr", rom_addr, 3);
    play = 1'b1; step(1); play = 1'b0;
    check("restart_addr", rom_addr, 0);
    check("restart_playing", playing, 1);
    step(2);
    check("restart_code", note_code, 25);
`endif
    stop = 1'b1; step(1); stop = 1'b0;
    check("stop_addr", rom_addr, 0);
    check("stop_playing", playing, 0);
    check("stop_code", note_code, 0);

    // Tempo x2, then x0.5 requested mid-step
    tempo_sel = 2'b01;
    play = 1'b1; step(1); play = 1'b0;
    step(7);
    check("x2_c7_addr", rom_addr, 0);
    step(1);
    check("x2_next_addr", rom_addr, 1);
    step(3);
    tempo_sel = 2'b10;
    step(4);
    check("midchange_c7_addr", rom_addr, 1);
    step(1);
    check("half_s2c0_addr", rom_addr, 2);
    step(3);
    check("half_c3_note_on", note_on, 0);
    step(1);
    check("half_c4_note_on", note_on, 1);
    step(27);
    check("half_c31_addr", rom_addr, 2);
    step(1);
    check("half_next_addr", rom_addr, 3);

    // stop + pause + play together mid-PLAY
    step(5);
    stop = 1'b1; pause = 1'b1; play = 1'b1;
    step(1);
    stop = 1'b0; pause = 1'b0; play = 1'b0;
    check("prio_addr", rom_addr, 0);
    check("prio_playing", playing, 0);
    check("prio_note_on", note_on, 0);

    // Asynchronous reset mid-note
    tempo_sel = 2'b00;
    play = 1'b1; step(1); play = 1'b0;
    step(6);
    check("prereset_note_on", note_on, 1);
    #2 RESET = 1'b1;
    #1;
    check("async_note_on", note_on, 0);
    check("async_addr", rom_addr, 0);
    check("async_playing", playing, 0);
    check("async_code", note_code, 0);
    step(1);
    RESET = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
